// File: rtl/wordle_guess_entry.sv
// Guess composer: buttons edit a five-letter ASCII buffer, and submit streams it out as C/curr_letter strobes.
// All outputs are registered. Defining WORDLE_AUTOSUBMIT_EN makes the fifth placed letter start the burst.
module wordle_guess_entry #(
  parameter int STROBE_GAP = 0
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnR,
  input  logic        BtnL,
  input  logic        BtnC,
  output logic [7:0]  sel_letter,
  output logic [2:0]  cursor,
  output logic [39:0] guess_buf,
  output logic [7:0]  curr_letter,
  output logic        C,
  output logic        busy
);

  typedef enum logic [1:0] {ST_EDIT, ST_SEND, ST_GAP} state_t;

  localparam logic [7:0]  SPACE    = 8'h20;
  localparam logic [7:0]  LET_A    = 8'h41;
  localparam logic [7:0]  LET_Z    = 8'h5A;
  localparam logic [39:0] BLANK    = {5{SPACE}};
  localparam logic [3:0]  GAP_LAST = 4'((STROBE_GAP > 0) ? (STROBE_GAP - 1) : 0);

  state_t          state_q, state_d;
  logic [7:0]      sel_q, sel_d;
  logic [2:0]      cur_q, cur_d;
  logic [0:4][7:0] slots_q, slots_d;
  logic [7:0]      letter_q, letter_d;
  logic            c_q, c_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      gap_q, gap_d;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EDIT;
      sel_q    <= LET_A;
      cur_q    <= 3'd0;
      slots_q  <= BLANK;
      letter_q <= 8'h00;
      c_q      <= 1'b0;
      idx_q    <= 3'd0;
      gap_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cur_q    <= cur_d;
      slots_q  <= slots_d;
      letter_q <= letter_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cur_d    = cur_q;
    slots_d  = slots_q;
    letter_d = letter_q;
    c_d      = 1'b0;
    idx_d    = idx_q;
    gap_d    = gap_q;
    case (state_q)
      ST_EDIT: begin
        if (enable) begin
          if (BtnC) begin
            if (cur_q == 3'd5) begin
              idx_d   = 3'd0;
              state_d = ST_SEND;
            end
          end else if (BtnL) begin
            if (cur_q != 3'd0) begin
              cur_d                  = cur_q - 3'd1;
              slots_d[cur_q - 3'd1]  = SPACE;
            end
          end else if (BtnR) begin
            if (cur_q < 3'd5) begin
              slots_d[cur_q] = sel_q;
              cur_d          = cur_q + 3'd1;
`ifdef WORDLE_AUTOSUBMIT_EN
              if (cur_q == 3'd4) begin
                idx_d   = 3'd0;
                state_d = ST_SEND;
              end
`endif
            end
          end else if (BtnU && !BtnD) begin
            sel_d = (sel_q == LET_Z) ? LET_A : sel_q + 8'd1;
          end else if (BtnD && !BtnU) begin
            sel_d = (sel_q == LET_A) ? LET_Z : sel_q - 8'd1;
          end
        end
      end
      ST_SEND: begin
        if (!enable) begin
          slots_d = BLANK;
          cur_d   = 3'd0;
          idx_d   = 3'd0;
          gap_d   = 4'd0;
          state_d = ST_EDIT;
        end else begin
          c_d      = 1'b1;
          letter_d = slots_q[idx_q];
          if (idx_q == 3'd4) begin
            // Last letter out: the buffer is freed for the next guess, selection kept.
            slots_d = BLANK;
            cur_d   = 3'd0;
            idx_d   = 3'd0;
            state_d = ST_EDIT;
          end else begin
            idx_d = idx_q + 3'd1;
            if (STROBE_GAP > 0) begin
              gap_d   = 4'd0;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (!enable) begin
          slots_d = BLANK;
          cur_d   = 3'd0;
          idx_d   = 3'd0;
          gap_d   = 4'd0;
          state_d = ST_EDIT;
        end else if (gap_q == GAP_LAST) begin
          gap_d   = 4'd0;
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_EDIT;
    endcase
  end

  assign sel_letter  = sel_q;
  assign cursor      = cur_q;
  assign guess_buf   = slots_q;
  assign curr_letter = letter_q;
  assign C           = c_q;
  assign busy        = (state_q != ST_EDIT);

endmodule

// File: tb/tb_wordle_guess_entry.sv
// Directed bench: instance a uses STROBE_GAP=0, instance b uses STROBE_GAP=2; both share the stimulus.
module tb_wordle_guess_entry;

  logic Clk = 1'b0;
  logic reset, enable, BtnU, BtnD, BtnR, BtnL, BtnC;

  logic [7:0]  a_sel, a_curr, b_sel, b_curr;
  logic [2:0]  a_cur, b_cur;
  logic [39:0] a_buf, b_buf;
  logic        a_C, a_busy, b_C, b_busy;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  wordle_guess_entry #(.STROBE_GAP(0)) dut_a (
    .Clk(Clk), .reset(reset), .enable(enable),
    .BtnU(BtnU), .BtnD(BtnD), .BtnR(BtnR), .BtnL(BtnL), .BtnC(BtnC),
    .sel_letter(a_sel), .cursor(a_cur), .guess_buf(a_buf),
    .curr_letter(a_curr), .C(a_C), .busy(a_busy)
  );

  wordle_guess_entry #(.STROBE_GAP(2)) dut_b (
    .Clk(Clk), .reset(reset), .enable(enable),
    .BtnU(BtnU), .BtnD(BtnD), .BtnR(BtnR), .BtnL(BtnL), .BtnC(BtnC),
    .sel_letter(b_sel), .cursor(b_cur), .guess_buf(b_buf),
    .curr_letter(b_curr), .C(b_C), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input logic u, input logic d, input logic r, input logic l, input logic c);
    BtnU = u; BtnD = d; BtnR = r; BtnL = l; BtnC = c;
    tick();
    BtnU = 1'b0; BtnD = 1'b0; BtnR = 1'b0; BtnL = 1'b0; BtnC = 1'b0;
  endtask

  // Steps BtnU until instance a shows the wanted letter (bounded to one lap of the alphabet).
  task automatic set_sel(input logic [7:0] t);
    for (int n = 0; n < 27 && a_sel !== t; n++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("set_sel", 40'(a_sel), 40'(t));
  endtask

  logic [7:0] robot [5];
  logic [7:0] tuvvv [5];
  int         c_seen;

  initial begin
    robot = '{8'h52, 8'h4F, 8'h42, 8'h4F, 8'h54};
    tuvvv = '{8'h54, 8'h55, 8'h56, 8'h56, 8'h56};
    reset = 1'b1; enable = 1'b0;
    BtnU = 1'b0; BtnD = 1'b0; BtnR = 1'b0; BtnL = 1'b0; BtnC = 1'b0;
    #12;
    check("rst_sel",  40'(a_sel),  40'h41);
    check("rst_cur",  40'(a_cur),  40'h0);
    check("rst_buf",  a_buf,       40'h2020202020);
    check("rst_curr", 40'(a_curr), 40'h00);
    check("rst_C",    40'(a_C),    40'h0);
    check("rst_busy", 40'(a_busy), 40'h0);
    reset = 1'b0; enable = 1'b1;
    tick();

    // Letter wrap
    repeat (25) pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_25U", 40'(a_sel), 40'h5A);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_Z_to_A", 40'(a_sel), 40'h41);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_A_to_Z", 40'(a_sel), 40'h5A);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("UD_together", 40'(a_sel), 40'h5A);
    enable = 1'b0;
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("disabled_sel", 40'(a_sel), 40'h5A);
    check("disabled_cur", 40'(a_cur), 40'h0);
    enable = 1'b1;

    // Backspace at cursor 0
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("L_at_0_cur", 40'(a_cur), 40'h0);
    check("L_at_0_buf", a_buf, 40'h2020202020);

    // Compose ROBOT
    for (int i = 0; i < 5; i++) begin
      set_sel(robot[i]);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
`ifdef WORDLE_AUTOSUBMIT_EN
    check("auto_robot_busy", 40'(a_busy), 40'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("auto_robot_C", 40'(a_C), 40'h1);
      check("auto_robot_letter", 40'(a_curr), 40'(robot[i]));
    end
    check("auto_robot_done", 40'(a_busy), 40'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) set_sel(robot[i]);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 3) break;
    end
    set_sel(robot[4]);
    // Fill slot 4 via BtnR would auto-submit, so the buffer stops at four letters here.
    check("auto_robot_cur4", 40'(a_cur), 40'h4);
`else
    check("robot_cur", 40'(a_cur), 40'h5);
    check("robot_buf", a_buf, 40'h524F424F54);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("R_at_5_buf", a_buf, 40'h524F424F54);
    check("R_at_5_cur", 40'(a_cur), 40'h5);

    // Submit with BtnL in the same cycle: burst starts, no backspace
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("CL_busy", 40'(a_busy), 40'h1);
    check("CL_cur",  40'(a_cur),  40'h5);
    check("CL_buf",  a_buf,       40'h524F424F54);
    check("CL_C",    40'(a_C),    40'h0);
    for (int i = 0; i < 5; i++) begin
      BtnU = (i < 3); BtnR = (i < 3);
      tick();
      check("robot_C", 40'(a_C), 40'h1);
      check("robot_letter", 40'(a_curr), 40'(robot[i]));
    end
    BtnU = 1'b0; BtnR = 1'b0;
    check("robot_busy_end", 40'(a_busy), 40'h0);
    check("robot_cur_end",  40'(a_cur),  40'h0);
    check("robot_buf_end",  a_buf,       40'h2020202020);
    check("robot_sel_kept", 40'(a_sel),  40'h54);
    tick();
    check("robot_C_off",    40'(a_C),    40'h0);
    check("robot_curr_hold", 40'(a_curr), 40'h54);
`endif

    // Restart from a known state for the boundary and burst tests
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    set_sel(8'h54);

    // Three letters, submit ignored, then backspace
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("three_buf", a_buf, 40'h5455562020);
    check("three_cur", 40'(a_cur), 40'h3);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("C_at_3_busy", 40'(a_busy), 40'h0);
    check("C_at_3_C", 40'(a_C), 40'h0);
    tick();
    check("C_at_3_C2", 40'(a_C), 40'h0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("L_at_3_buf", a_buf, 40'h5455202020);
    check("L_at_3_cur", 40'(a_cur), 40'h2);

    // Fifth BtnR: autosubmit starts the burst, otherwise BtnC is needed
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fifth_R_cur", 40'(a_cur), 40'h5);
`ifdef WORDLE_AUTOSUBMIT_EN
    check("fifth_R_busy", 40'(a_busy), 40'h1);
`else
    check("fifth_R_busy", 40'(a_busy), 40'h0);
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("submit_busy", 40'(a_busy), 40'h1);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check("tuvvv_C", 40'(a_C), 40'h1);
      check("tuvvv_letter", 40'(a_curr), 40'(tuvvv[i]));
    end
    check("tuvvv_busy_end", 40'(a_busy), 40'h0);

    // Gap of 2 on instance b, with enable abort after the second strobe
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("gap_buf", b_buf, 40'h4142434445);
`ifndef WORDLE_AUTOSUBMIT_EN
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    check("gap_busy", 40'(b_busy), 40'h1);
    tick();
    check("gap_s1_C", 40'(b_C), 40'h1);
    check("gap_s1_letter", 40'(b_curr), 40'h41);
    tick();
    check("gap_idle1_C", 40'(b_C), 40'h0);
    tick();
    check("gap_idle2_C", 40'(b_C), 40'h0);
    check("gap_idle2_hold", 40'(b_curr), 40'h41);
    tick();
    check("gap_s2_C", 40'(b_C), 40'h1);
    check("gap_s2_letter", 40'(b_curr), 40'h42);
    enable = 1'b0;
    tick();
    check("abort_C",    40'(b_C),    40'h0);
    check("abort_cur",  40'(b_cur),  40'h0);
    check("abort_busy", 40'(b_busy), 40'h0);
    check("abort_buf",  b_buf,       40'h2020202020);
    enable = 1'b1;
    c_seen = 0;
    repeat (8) begin
      tick();
      if (b_C === 1'b1) c_seen++;
    end
    check("abort_no_more_C", 40'(c_seen), 40'h0);

    // Reset mid-burst on instance a
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    repeat (5) pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifndef WORDLE_AUTOSUBMIT_EN
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    tick(); tick(); tick();
    check("mid_s3_C", 40'(a_C), 40'h1);
    check("mid_s3_letter", 40'(a_curr), 40'h41);
    reset = 1'b1;
    #1;
    check("mid_rst_sel",  40'(a_sel),  40'h41);
    check("mid_rst_cur",  40'(a_cur),  40'h0);
    check("mid_rst_buf",  a_buf,       40'h2020202020);
    check("mid_rst_curr", 40'(a_curr), 40'h00);
    check("mid_rst_C",    40'(a_C),    40'h0);
    check("mid_rst_busy", 40'(a_busy), 40'h0);
    tick();
    reset = 1'b0;
    c_seen = 0;
    repeat (6) begin
      tick();
      if (a_C === 1'b1) c_seen++;
    end
    check("mid_rst_no_more_C", 40'(c_seen), 40'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
